multicycle_control_unit: RTL and testbench

Control unit for the multicycle RV32I datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ULA and one memory port. It drives the write enables and multiplexer selects of the datapath from the instruction-register fields and the ULA `Zero` flag. It supports R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), lw, sw, beq and jal, and adds branch, jump and illegal-opcode handling.

---
 rtl/control_pkg.sv | 62 ++++++
 rtl/multicycle_control_unit_if.sv | 34 +++
 rtl/multicycle_control_unit_ula_decoder.sv | 34 +++
 rtl/multicycle_control_unit.sv | 110 +++++++++++
 tb/tb_multicycle_control_unit.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes
// and datapath select/operation codes.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ULA    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and flag in, enables
// and selects out.
interface multicycle_control_unit_if #(
  parameter int unsigned ALU_CTRL_W = 3
);
  logic [6:0]            OP;
  logic [2:0]            Funct3;
  logic [6:0]            Funct7;
  logic                  Zero;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  MemWrite;
  logic                  RegWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ULASrcA;
  logic [1:0]            ULASrcB;
  logic [1:0]            ImmSrc;
  logic [ALU_CTRL_W-1:0] ULAControl;
  logic                  InstrDone;
  logic                  Illegal;

  modport master (
    input  OP, Funct3, Funct7, Zero,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ULASrcA, ULASrcB, ImmSrc, ULAControl, InstrDone, Illegal
  );

  modport slave (
    output OP, Funct3, Funct7, Zero,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ULASrcA, ULASrcB, ImmSrc, ULAControl, InstrDone, Illegal
  );
endinterface

// File: rtl/multicycle_control_unit_ula_decoder.sv
// ULA operation decode from FSM ALUOp and instruction function fields.
module ula_decoder
  import control_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic [1:0]            ALUOp,
  input  logic [2:0]            Funct3,
  input  logic                  Funct7b5,
  input  logic                  OPb5,
  output logic [ALU_CTRL_W-1:0] ULAControl
);
  logic [2:0] ctrl;

  always_comb begin
    ctrl = ULA_ADD;
    case (ALUOp)
      ALUOP_SUB: ctrl = ULA_SUB;
      ALUOP_FUNCT: begin
        // OP[5] separates R-type from I-type, so addi never becomes sub
        case (Funct3)
          3'b000:  ctrl = (OPb5 && Funct7b5) ? ULA_SUB : ULA_ADD;
          3'b010:  ctrl = ULA_SLT;
          3'b110:  ctrl = ULA_OR;
          3'b111:  ctrl = ULA_AND;
          default: ctrl = ULA_ADD;
        endcase
      end
      default: ctrl = ULA_ADD;
    endcase
  end

  assign ULAControl = ALU_CTRL_W'(ctrl);
endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle RV32I datapath (fetch, decode, execute,
// memory, write-back) over a shared ULA and memory port.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);
  state_t     state_q, state_d;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    alu_op        = ALUOP_ADD;
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ULASrcA   = SRCA_PC;
    bus.ULASrcB   = SRCB_RS2;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite = 1'b1; bus.PCWrite = 1'b1;
        bus.ULASrcB = SRCB_FOUR; bus.ResultSrc = RES_ULA;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ULASrcA = SRCA_OLDPC; bus.ULASrcB = SRCB_IMM;
        case (bus.OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            bus.Illegal = 1'b1; bus.InstrDone = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ULASrcA = SRCA_RS1; bus.ULASrcB = SRCB_IMM;
        state_d = (bus.OP == OP_LW) ? S_MEMREAD : S_MEMWR;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA; bus.RegWrite = 1'b1; bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1; bus.MemWrite = 1'b1; bus.InstrDone = 1'b1;
      end
      S_EXECR: begin
        bus.ULASrcA = SRCA_RS1; alu_op = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        bus.ULASrcA = SRCA_RS1; bus.ULASrcB = SRCB_IMM; alu_op = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1; bus.InstrDone = 1'b1;
      end
      S_BEQ: begin
        bus.ULASrcA = SRCA_RS1; alu_op = ALUOP_SUB;
        bus.PCWrite = bus.Zero; bus.InstrDone = 1'b1;
      end
      S_JAL: begin
        bus.ULASrcA = SRCA_OLDPC; bus.ULASrcB = SRCB_FOUR; bus.PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset overrides whatever state is current: selects show FETCH, no writes
    if (reset) begin
      bus.PCWrite   = 1'b0; bus.IRWrite  = 1'b0; bus.MemWrite = 1'b0;
      bus.RegWrite  = 1'b0; bus.InstrDone = 1'b0; bus.Illegal = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ResultSrc = RES_ULA;
      bus.ULASrcA   = SRCA_PC;
      bus.ULASrcB   = SRCB_FOUR;
      alu_op        = ALUOP_ADD;
      state_d       = S_FETCH;
    end
  end

  assign bus.ImmSrc = imm_src(bus.OP);

  ula_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_ula_decoder (
    .ALUOp      (alu_op),
    .Funct3     (bus.Funct3),
    .Funct7b5   (bus.Funct7[5]),
    .OPb5       (bus.OP[5]),
    .ULAControl (bus.ULAControl)
  );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected output
// vectors are queued with each instruction and compared on the falling edge.
module tb_multicycle_control_unit;

  typedef enum {T_RST, T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB, T_BEQ, T_JAL} tst_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_CTRL_W(3)) bus();

  multicycle_control_unit #(.ALU_CTRL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [17:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_model(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Vector layout: PCWrite AdrSrc IRWrite MemWrite RegWrite ResultSrc ULASrcA ULASrcB ImmSrc ULAControl InstrDone Illegal
  function automatic logic [17:0] model(input tst_t st, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic z);
    logic pcw, adr, irw, mw, rw, done, ill;
    logic [1:0] res, sa, sbb, imm;
    logic [2:0] ula;
    {pcw, adr, irw, mw, rw, done, ill} = '0;
    res = 2'b00; sa = 2'b00; sbb = 2'b00; ula = 3'b000;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (st)
      T_RST: begin sbb = 2'b10; res = 2'b10; end
      T_F:   begin pcw = 1; irw = 1; sbb = 2'b10; res = 2'b10; end
      T_D: begin
        sa = 2'b01; sbb = 2'b01;
        if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})) begin
          done = 1; ill = 1;
        end
      end
      T_MA:  begin sa = 2'b10; sbb = 2'b01; end
      T_MR:  adr = 1;
      T_MWB: begin res = 2'b01; rw = 1; done = 1; end
      T_MW:  begin adr = 1; mw = 1; done = 1; end
      T_ER:  begin sa = 2'b10; ula = alu_model(f3, f7[5]); end
      T_EI:  begin sa = 2'b10; sbb = 2'b01; ula = alu_model(f3, 1'b0); end
      T_AWB: begin rw = 1; done = 1; end
      T_BEQ: begin sa = 2'b10; ula = 3'b001; pcw = z; done = 1; end
      T_JAL: begin sa = 2'b01; sbb = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, irw, mw, rw, res, sa, sbb, imm, ula, done, ill};
  endfunction

  task automatic push(input string tag, input tst_t st);
    exp_q.push_back(model(st, bus.OP, bus.Funct3, bus.Funct7, bus.Zero));
    tag_q.push_back(tag);
  endtask

  task automatic push_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic z);
    bus.OP = op; bus.Funct3 = f3; bus.Funct7 = f7; bus.Zero = z;
    push({name, "_fetch"}, T_F);
    push({name, "_decode"}, T_D);
    case (op)
      7'b0000011: begin push({name, "_memadr"}, T_MA); push({name, "_memread"}, T_MR); push({name, "_memwb"}, T_MWB); end
      7'b0100011: begin push({name, "_memadr"}, T_MA); push({name, "_memwr"}, T_MW); end
      7'b0110011: begin push({name, "_execr"}, T_ER); push({name, "_aluwb"}, T_AWB); end
      7'b0010011: begin push({name, "_execi"}, T_EI); push({name, "_aluwb"}, T_AWB); end
      7'b1100011: push({name, "_beq"}, T_BEQ);
      7'b1101111: begin push({name, "_jal"}, T_JAL); push({name, "_aluwb"}, T_AWB); end
      default: ;
    endcase
  endtask

  // Returns just after the rising edge that follows the last expected cycle
  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      tag_q.delete();
      @(posedge clk);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(),
            {bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.ResultSrc,
             bus.ULASrcA, bus.ULASrcB, bus.ImmSrc, bus.ULAControl, bus.InstrDone, bus.Illegal},
            exp_q.pop_front());
    end
  end

  initial begin
    bus.OP = 7'b0110011; bus.Funct3 = 3'b000; bus.Funct7 = 7'b0100000; bus.Zero = 1'b0;
    reset = 1'b1;
    push("reset0", T_RST);
    push("reset1", T_RST);
    drain();
    reset = 1'b0;

    push_instr("sub",   7'b0110011, 3'b000, 7'b0100000, 1'b0); drain();
    push_instr("lw",    7'b0000011, 3'b010, 7'b0000000, 1'b0); drain();
    push_instr("sw",    7'b0100011, 3'b010, 7'b0000000, 1'b0); drain();
    push_instr("beqt",  7'b1100011, 3'b000, 7'b0000000, 1'b1); drain();
    push_instr("beqn",  7'b1100011, 3'b000, 7'b0000000, 1'b0); drain();
    push_instr("jal",   7'b1101111, 3'b000, 7'b0000000, 1'b1); drain();
    push_instr("ill",   7'b1111111, 3'b000, 7'b0000000, 1'b0); drain();
    push_instr("add",   7'b0110011, 3'b000, 7'b0000000, 1'b0); drain();
    push_instr("and",   7'b0110011, 3'b111, 7'b0000000, 1'b0); drain();
    push_instr("or",    7'b0110011, 3'b110, 7'b0000000, 1'b0); drain();
    push_instr("slt",   7'b0110011, 3'b010, 7'b0000000, 1'b0); drain();
    push_instr("sll",   7'b0110011, 3'b001, 7'b0000000, 1'b0); drain();
    push_instr("addi",  7'b0010011, 3'b000, 7'b0100000, 1'b0); drain();
    push_instr("andi",  7'b0010011, 3'b111, 7'b0000000, 1'b0); drain();
    push_instr("ori",   7'b0010011, 3'b110, 7'b0000000, 1'b0); drain();
    push_instr("slti",  7'b0010011, 3'b010, 7'b0000000, 1'b0); drain();
    push_instr("ill0",  7'b0000000, 3'b000, 7'b0000000, 1'b1); drain();

    // Abort a store while it sits in MEMWR
    bus.OP = 7'b0100011; bus.Funct3 = 3'b010; bus.Funct7 = 7'b0000000; bus.Zero = 1'b0;
    push("swab_fetch", T_F);
    push("swab_decode", T_D);
    push("swab_memadr", T_MA);
    drain();
    reset = 1'b1;
    push("swab_reset", T_RST);
    drain();
    reset = 1'b0;
    push_instr("post_addi", 7'b0010011, 3'b000, 7'b0000000, 1'b0); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
